// File: rtl/apb_uart_regs_fifo.sv
// APB register block for the uart16550 core.
// Holds the TX/RX FIFOs, line control and divisor registers, sticky line-status
// errors and a prioritised interrupt identification with a registered irq.
// Zero-wait-state APB3 slave; everything runs on PCLK with a synchronous reset.
module apb_uart_regs_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int PDATA_W    = 32
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic [2:0]         PADDR,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [PDATA_W-1:0] PWDATA,
  output logic [PDATA_W-1:0] PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               rx_parity_err,
  input  logic               rx_frame_err,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic               tx_busy,
  output logic [1:0]         word_length,
  output logic               stop_bits,
  output logic [2:0]         parity,
  output logic               set_break,
  output logic [15:0]        divisor,
  output logic               irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] TRIG_QTR = CW'(FIFO_DEPTH / 4);
  localparam logic [CW-1:0] TRIG_HLF = CW'(FIFO_DEPTH / 2);
  localparam logic [CW-1:0] TRIG_NRF = CW'(FIFO_DEPTH - 2);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_IER  = 3'd1;
  localparam logic [2:0] ADDR_ISR  = 3'd2;
  localparam logic [2:0] ADDR_LCR  = 3'd3;
  localparam logic [2:0] ADDR_MCR  = 3'd4;
  localparam logic [2:0] ADDR_LSR  = 3'd5;
  localparam logic [2:0] ADDR_MSR  = 3'd6;
  localparam logic [2:0] ADDR_SPR  = 3'd7;

  localparam logic [3:0] ID_LINE = 4'h6;
  localparam logic [3:0] ID_RXD  = 4'h4;
  localparam logic [3:0] ID_THRE = 4'h2;
  localparam logic [3:0] ID_NONE = 4'h1;

  // Storage and state
  logic [7:0]    tx_mem_r [FIFO_DEPTH];
  logic [7:0]    rx_mem_r [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr_r, tx_rptr_r, rx_wptr_r, rx_rptr_r;
  logic [CW-1:0] tx_count_r, rx_count_r;
  logic [CW-1:0] tx_count_nxt_s, rx_count_nxt_s;
  logic [2:0]    ier_r;
  logic [7:0]    lcr_r, mcr_r, spr_r, dll_r, dlm_r;
  logic [1:0]    rx_trig_r;
  logic          ovr_r, perr_r, ferr_r, thre_pend_r, irq_r;

  // Decoded strobes; everything is masked while reset is held so a beat in
  // flight during reset leaves no trace.
  logic access_s, wr_s, rd_s, dlab_s;
  logic thr_wr_s, dll_wr_s, ier_wr_s, dlm_wr_s, fcr_wr_s, lcr_wr_s, mcr_wr_s, spr_wr_s, ro_wr_s;
  logic rhr_rd_s, isr_rd_s, lsr_rd_s;
  logic tx_empty_s, tx_full_s, tx_pop_s, tx_push_s, tx_flush_s;
  logic rx_empty_s, rx_full_s, rx_pop_s, rx_push_s, rx_flush_s, rx_in_s;
  logic ovr_set_s, perr_set_s, ferr_set_s;
  logic thre_set_s, thre_clr_s;
  logic [CW-1:0] trig_lvl_s;
  logic [3:0]    isr_id_s;
  logic [7:0]    isr_val_s, lsr_val_s, rd_data_s;
  logic [7:0]    tx_head_s, rx_head_s;
  logic          unused_s;

  assign access_s = PSEL & PENABLE & ~PRESET;
  assign wr_s     = access_s & PWRITE;
  assign rd_s     = access_s & ~PWRITE;
  assign dlab_s   = lcr_r[7];

  assign thr_wr_s = wr_s & (PADDR == ADDR_DATA) & ~dlab_s;
  assign dll_wr_s = wr_s & (PADDR == ADDR_DATA) & dlab_s;
  assign ier_wr_s = wr_s & (PADDR == ADDR_IER) & ~dlab_s;
  assign dlm_wr_s = wr_s & (PADDR == ADDR_IER) & dlab_s;
  assign fcr_wr_s = wr_s & (PADDR == ADDR_ISR);
  assign lcr_wr_s = wr_s & (PADDR == ADDR_LCR);
  assign mcr_wr_s = wr_s & (PADDR == ADDR_MCR);
  assign spr_wr_s = wr_s & (PADDR == ADDR_SPR);
  assign ro_wr_s  = wr_s & ((PADDR == ADDR_LSR) | (PADDR == ADDR_MSR));
  assign rhr_rd_s = rd_s & (PADDR == ADDR_DATA) & ~dlab_s;
  assign isr_rd_s = rd_s & (PADDR == ADDR_ISR);
  assign lsr_rd_s = rd_s & (PADDR == ADDR_LSR);

  // TX FIFO control: a pop in the same cycle frees the slot for a write to a full FIFO
  assign tx_empty_s = (tx_count_r == CNT_ZERO);
  assign tx_full_s  = (tx_count_r == CNT_FULL);
  assign tx_pop_s   = ~tx_empty_s & tx_ready & ~PRESET;
  assign tx_push_s  = thr_wr_s & (~tx_full_s | tx_pop_s);
  assign tx_flush_s = fcr_wr_s & PWDATA[2];
  assign tx_head_s  = tx_mem_r[tx_rptr_r];

  // RX FIFO control: flush beats a concurrent push, a full FIFO drops unless popped
  assign rx_in_s    = rx_valid & ~PRESET;
  assign rx_empty_s = (rx_count_r == CNT_ZERO);
  assign rx_full_s  = (rx_count_r == CNT_FULL);
  assign rx_pop_s   = rhr_rd_s & ~rx_empty_s;
  assign rx_flush_s = fcr_wr_s & PWDATA[1];
  assign rx_push_s  = rx_in_s & (~rx_full_s | rx_pop_s) & ~rx_flush_s;
  assign ovr_set_s  = rx_in_s & rx_full_s & ~rx_pop_s & ~rx_flush_s;
  assign perr_set_s = rx_in_s & rx_parity_err;
  assign ferr_set_s = rx_in_s & rx_frame_err;
  assign rx_head_s  = rx_mem_r[rx_rptr_r];

  // Next TX occupancy; flush overrides any concurrent push or pop
  always_comb begin
    tx_count_nxt_s = tx_count_r;
    if (tx_flush_s) begin
      tx_count_nxt_s = CNT_ZERO;
    end else if (tx_push_s && !tx_pop_s) begin
      tx_count_nxt_s = tx_count_r + CNT_ONE;
    end else if (!tx_push_s && tx_pop_s) begin
      tx_count_nxt_s = tx_count_r - CNT_ONE;
    end else begin
      tx_count_nxt_s = tx_count_r;
    end
  end

  // Next RX occupancy; flush overrides any concurrent push or pop
  always_comb begin
    rx_count_nxt_s = rx_count_r;
    if (rx_flush_s) begin
      rx_count_nxt_s = CNT_ZERO;
    end else if (rx_push_s && !rx_pop_s) begin
      rx_count_nxt_s = rx_count_r + CNT_ONE;
    end else if (!rx_push_s && rx_pop_s) begin
      rx_count_nxt_s = rx_count_r - CNT_ONE;
    end else begin
      rx_count_nxt_s = rx_count_r;
    end
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_wptr_r  <= PTR_ZERO;
      tx_rptr_r  <= PTR_ZERO;
      tx_count_r <= CNT_ZERO;
    end else begin
      tx_count_r <= tx_count_nxt_s;
      if (tx_flush_s) begin
        tx_wptr_r <= PTR_ZERO;
        tx_rptr_r <= PTR_ZERO;
      end else begin
        if (tx_push_s) tx_wptr_r <= tx_wptr_r + PTR_ONE;
        if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + PTR_ONE;
      end
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_wptr_r  <= PTR_ZERO;
      rx_rptr_r  <= PTR_ZERO;
      rx_count_r <= CNT_ZERO;
    end else begin
      rx_count_r <= rx_count_nxt_s;
      if (rx_flush_s) begin
        rx_wptr_r <= PTR_ZERO;
        rx_rptr_r <= PTR_ZERO;
      end else begin
        if (rx_push_s) rx_wptr_r <= rx_wptr_r + PTR_ONE;
        if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + PTR_ONE;
      end
    end
  end

  // FIFO storage; contents are don't-care when the matching count is zero
  always_ff @(posedge PCLK) begin
    if (tx_push_s && !tx_flush_s) tx_mem_r[tx_wptr_r] <= PWDATA[7:0];
    if (rx_push_s)                rx_mem_r[rx_wptr_r] <= rx_data;
  end

  // Control registers written from the bus
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ier_r     <= 3'b000;
      lcr_r     <= 8'h00;
      mcr_r     <= 8'h00;
      spr_r     <= 8'h00;
      dll_r     <= 8'h00;
      dlm_r     <= 8'h00;
      rx_trig_r <= 2'b00;
    end else begin
      if (ier_wr_s) ier_r     <= PWDATA[2:0];
      if (lcr_wr_s) lcr_r     <= PWDATA[7:0];
      if (mcr_wr_s) mcr_r     <= PWDATA[7:0];
      if (spr_wr_s) spr_r     <= PWDATA[7:0];
      if (dll_wr_s) dll_r     <= PWDATA[7:0];
      if (dlm_wr_s) dlm_r     <= PWDATA[7:0];
      if (fcr_wr_s) rx_trig_r <= PWDATA[7:6];
    end
  end

  // Sticky line-status errors: an LSR read clears them, a same-cycle error wins
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ovr_r  <= 1'b0;
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
    end else begin
      if (ovr_set_s)     ovr_r  <= 1'b1;
      else if (lsr_rd_s) ovr_r  <= 1'b0;
      if (perr_set_s)    perr_r <= 1'b1;
      else if (lsr_rd_s) perr_r <= 1'b0;
      if (ferr_set_s)    ferr_r <= 1'b1;
      else if (lsr_rd_s) ferr_r <= 1'b0;
    end
  end

  // Receive trigger level selected by the last FCR write
  always_comb begin
    trig_lvl_s = CNT_ONE;
    case (rx_trig_r)
      2'b00:   trig_lvl_s = CNT_ONE;
      2'b01:   trig_lvl_s = TRIG_QTR;
      2'b10:   trig_lvl_s = TRIG_HLF;
      2'b11:   trig_lvl_s = TRIG_NRF;
      default: trig_lvl_s = CNT_ONE;
    endcase
  end

  // Interrupt identification, highest priority cause first
  always_comb begin
    isr_id_s = ID_NONE;
    if (ier_r[2] && (ovr_r || perr_r || ferr_r)) begin
      isr_id_s = ID_LINE;
    end else if (ier_r[0] && (rx_count_r >= trig_lvl_s)) begin
      isr_id_s = ID_RXD;
    end else if (ier_r[1] && thre_pend_r) begin
      isr_id_s = ID_THRE;
    end else begin
      isr_id_s = ID_NONE;
    end
  end

  assign isr_val_s = {2'b11, 2'b00, isr_id_s};
  assign lsr_val_s = {1'b0, tx_empty_s & ~tx_busy, tx_empty_s, 1'b0,
                      ferr_r, perr_r, ovr_r, ~rx_empty_s};

  // THRE becomes pending when TX drains to empty or when THRE is enabled on an empty FIFO
  assign thre_set_s = ((tx_count_r == CNT_ONE) && (tx_count_nxt_s == CNT_ZERO)) |
                      (ier_wr_s & PWDATA[1] & ~ier_r[1] & tx_empty_s);
  assign thre_clr_s = thr_wr_s | (isr_rd_s & (isr_id_s == ID_THRE));

  // THRE pending flag; a same-cycle set takes precedence over a clear
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      thre_pend_r <= 1'b0;
    end else if (thre_set_s) begin
      thre_pend_r <= 1'b1;
    end else if (thre_clr_s) begin
      thre_pend_r <= 1'b0;
    end
  end

  // Registered interrupt request, follows the current cause one cycle later
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= (isr_id_s != ID_NONE);
    end
  end

  // Read data mux, only driven during the access phase of a read
  always_comb begin
    rd_data_s = 8'h00;
    if (rd_s) begin
      case (PADDR)
        ADDR_DATA: rd_data_s = dlab_s ? dll_r : (rx_empty_s ? 8'h00 : rx_head_s);
        ADDR_IER:  rd_data_s = dlab_s ? dlm_r : {5'b00000, ier_r};
        ADDR_ISR:  rd_data_s = isr_val_s;
        ADDR_LCR:  rd_data_s = lcr_r;
        ADDR_MCR:  rd_data_s = mcr_r;
        ADDR_LSR:  rd_data_s = lsr_val_s;
        ADDR_MSR:  rd_data_s = 8'h00;
        ADDR_SPR:  rd_data_s = spr_r;
        default:   rd_data_s = 8'h00;
      endcase
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // Zero-extend the byte-wide register data onto the APB bus
  always_comb begin
    PRDATA      = {PDATA_W{1'b0}};
    PRDATA[7:0] = rd_data_s;
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = ro_wr_s | (thr_wr_s & ~tx_push_s) | (rhr_rd_s & rx_empty_s);

  assign tx_valid    = ~tx_empty_s;
  assign tx_data     = tx_empty_s ? 8'h00 : tx_head_s;
  assign word_length = lcr_r[1:0];
  assign stop_bits   = lcr_r[2];
  assign parity      = lcr_r[5:3];
  assign set_break   = lcr_r[6];
  assign divisor     = {dlm_r, dll_r};
  assign irq         = irq_r;

  // Upper write-data bits are deliberately ignored
  assign unused_s = ^PWDATA;

endmodule

// File: tb/tb_apb_uart_regs_fifo.sv
// Self-checking bench for apb_uart_regs_fifo: directed APB/UART stimulus,
// a queue-based reference model compared every cycle, plus literal checks.
module tb_apb_uart_regs_fifo;

  localparam int DEPTH = 16;

  logic        PCLK, PRESET;
  logic [2:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_parity_err, rx_frame_err;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_busy;
  logic [1:0]  word_length;
  logic        stop_bits;
  logic [2:0]  parity;
  logic        set_break;
  logic [15:0] divisor;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  apb_uart_regs_fifo #(.FIFO_DEPTH(DEPTH), .PDATA_W(32)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .word_length(word_length),
    .stop_bits(stop_bits), .parity(parity), .set_break(set_break),
    .divisor(divisor), .irq(irq)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [2:0] m_ier = 3'b000;
  logic [7:0] m_lcr = 8'h00, m_mcr = 8'h00, m_spr = 8'h00, m_dll = 8'h00, m_dlm = 8'h00;
  logic [1:0] m_trig = 2'b00;
  logic m_ovr = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_thre = 1'b0, m_irq = 1'b0;

  function automatic int trig_level(input logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return DEPTH / 4;
      2'b10:   return DEPTH / 2;
      default: return DEPTH - 2;
    endcase
  endfunction

  function automatic logic [7:0] m_isr();
    if (m_ier[2] && (m_ovr || m_perr || m_ferr)) return 8'hC6;
    if (m_ier[0] && (rxq.size() >= trig_level(m_trig))) return 8'hC4;
    if (m_ier[1] && m_thre) return 8'hC2;
    return 8'hC1;
  endfunction

  function automatic logic [7:0] m_lsr();
    logic [7:0] v;
    v = 8'h00;
    if (rxq.size() != 0) v = v | 8'h01;
    if (m_ovr)  v = v | 8'h02;
    if (m_perr) v = v | 8'h04;
    if (m_ferr) v = v | 8'h08;
    if (txq.size() == 0) v = v | 8'h20;
    if (txq.size() == 0 && !tx_busy) v = v | 8'h40;
    return v;
  endfunction

  function automatic logic [7:0] m_rdata();
    if (PRESET || !(PSEL && PENABLE && !PWRITE)) return 8'h00;
    case (PADDR)
      3'd0: return m_lcr[7] ? m_dll : ((rxq.size() > 0) ? rxq[0] : 8'h00);
      3'd1: return m_lcr[7] ? m_dlm : {5'b00000, m_ier};
      3'd2: return m_isr();
      3'd3: return m_lcr;
      3'd4: return m_mcr;
      3'd5: return m_lsr();
      3'd7: return m_spr;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic m_err();
    logic acc, dl;
    acc = PSEL && PENABLE && !PRESET;
    dl  = m_lcr[7];
    if (!acc) return 1'b0;
    if (PWRITE && (PADDR == 3'd5 || PADDR == 3'd6)) return 1'b1;
    if (PWRITE && PADDR == 3'd0 && !dl && txq.size() == DEPTH && !tx_ready) return 1'b1;
    if (!PWRITE && PADDR == 3'd0 && !dl && rxq.size() == 0) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model across the coming clock edge using the current inputs
  task automatic model_step();
    logic acc, wr, rd, dl, tpop, rpop, thr, rflush, tflush;
    logic [7:0] isr_now, junk;
    int tx_before, rx_before;
    if (PRESET) begin
      txq.delete(); rxq.delete();
      m_ier = 3'b000; m_lcr = 8'h00; m_mcr = 8'h00; m_spr = 8'h00;
      m_dll = 8'h00; m_dlm = 8'h00; m_trig = 2'b00;
      m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_thre = 1'b0; m_irq = 1'b0;
      return;
    end
    acc = PSEL && PENABLE; wr = acc && PWRITE; rd = acc && !PWRITE; dl = m_lcr[7];
    isr_now = m_isr();
    tx_before = txq.size(); rx_before = rxq.size();
    thr    = wr && PADDR == 3'd0 && !dl;
    rflush = wr && PADDR == 3'd2 && PWDATA[1];
    tflush = wr && PADDR == 3'd2 && PWDATA[2];
    tpop = (tx_before > 0) && tx_ready;
    if (tpop) junk = txq.pop_front();
    if (thr && (tx_before < DEPTH || tpop)) txq.push_back(PWDATA[7:0]);
    rpop = rd && PADDR == 3'd0 && !dl && rx_before > 0;
    if (rpop) junk = rxq.pop_front();
    if (rd && PADDR == 3'd5) begin m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; end
    if (rx_valid) begin
      if (rx_before < DEPTH || rpop) rxq.push_back(rx_data);
      else if (!rflush) m_ovr = 1'b1;
      if (rx_parity_err) m_perr = 1'b1;
      if (rx_frame_err)  m_ferr = 1'b1;
    end
    if (rflush) rxq.delete();
    if (tflush) txq.delete();
    if (thr || (rd && PADDR == 3'd2 && isr_now == 8'hC2)) m_thre = 1'b0;
    if ((tx_before == 1 && txq.size() == 0) ||
        (wr && PADDR == 3'd1 && !dl && PWDATA[1] && !m_ier[1] && tx_before == 0)) m_thre = 1'b1;
    if (wr) begin
      case (PADDR)
        3'd0: if (dl) m_dll = PWDATA[7:0];
        3'd1: if (dl) m_dlm = PWDATA[7:0]; else m_ier = PWDATA[2:0];
        3'd2: m_trig = PWDATA[7:6];
        3'd3: m_lcr = PWDATA[7:0];
        3'd4: m_mcr = PWDATA[7:0];
        3'd7: m_spr = PWDATA[7:0];
        default: ;
      endcase
    end
    m_irq = (isr_now != 8'hC1);
  endtask

  // Per-cycle compare against the model, then step the model
  initial begin
    forever begin
      @(negedge PCLK);
      cmp("PRDATA", PRDATA, {24'h0, m_rdata()});
      cmp("PSLVERR", {31'h0, PSLVERR}, {31'h0, m_err()});
      cmp("PREADY", {31'h0, PREADY}, 32'h1);
      cmp("irq", {31'h0, irq}, {31'h0, m_irq});
      cmp("tx_valid", {31'h0, tx_valid}, {31'h0, (txq.size() > 0)});
      if (txq.size() > 0) cmp("tx_data", {24'h0, tx_data}, {24'h0, txq[0]});
      cmp("divisor", {16'h0, divisor}, {16'h0, m_dlm, m_dll});
      cmp("lcr_fields", {24'h0, set_break, parity, stop_bits, word_length}, {25'h0, m_lcr[6:0]});
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic apb(input logic w, input logic [2:0] a, input logic [7:0] d,
                     input logic [1:0] side, output logic [7:0] rdat, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = {24'hA5A5A5, d};
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (side[0]) tx_ready = 1'b1;
    if (side[1]) begin rx_valid = 1'b1; rx_data = 8'hFF; rx_frame_err = 1'b1; end
    @(negedge PCLK);
    rdat = PRDATA[7:0]; err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    if (side[0]) tx_ready = 1'b0;
    if (side[1]) begin rx_valid = 1'b0; rx_frame_err = 1'b0; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] r; logic e;
    apb(1'b1, a, d, 2'b00, r, e);
  endtask

  task automatic wr_err(input string nm, input logic [2:0] a, input logic [7:0] d,
                        input logic [1:0] side, input logic exp_err);
    logic [7:0] r; logic e;
    apb(1'b1, a, d, side, r, e);
    cmp(nm, {31'h0, e}, {31'h0, exp_err});
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [1:0] side,
                        input logic [7:0] exp);
    logic [7:0] r; logic e;
    apb(1'b0, a, 8'h00, side, r, e);
    cmp(nm, {24'h0, r}, {24'h0, exp});
  endtask

  task automatic rx_push(input logic [7:0] d, input logic pe, input logic fe);
    @(posedge PCLK); #1;
    rx_valid = 1'b1; rx_data = d; rx_parity_err = pe; rx_frame_err = fe;
    @(posedge PCLK); #1;
    rx_valid = 1'b0; rx_parity_err = 1'b0; rx_frame_err = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_rd [8];
    logic [31:0] exp_tx;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 3'd0;
    PWDATA = 32'h0; rx_data = 8'h00; rx_valid = 1'b0; rx_parity_err = 1'b0;
    rx_frame_err = 1'b0; tx_ready = 1'b0; tx_busy = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // 1: reset values of every register
    @(negedge PCLK);
    cmp("reset_irq", {31'h0, irq}, 32'h0);
    exp_rd = '{8'h00, 8'h00, 8'hC1, 8'h00, 8'h00, 8'h60, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) rd_chk("reset_read", 3'(i), 2'b00, exp_rd[i]);

    // 2: divisor latch and line control fields
    wr(3'd3, 8'h80);
    wr(3'd0, 8'h45);
    wr(3'd1, 8'h01);
    wr(3'd3, 8'h1B);
    @(negedge PCLK);
    cmp("divisor_lit", {16'h0, divisor}, 32'h0145);
    cmp("word_length_lit", {30'h0, word_length}, 32'd3);
    cmp("parity_lit", {29'h0, parity}, 32'd3);
    cmp("stop_bits_lit", {31'h0, stop_bits}, 32'd0);
    rd_chk("lcr_read", 3'd3, 2'b00, 8'h1B);
    wr_err("ro_write_err", 3'd5, 8'hFF, 2'b00, 1'b1);

    // 3: TX fill to full, overflow, full+pop+write, ordered drain
    for (int i = 0; i < 16; i++) wr_err("thr_fill_err", 3'd0, 8'(8'h10 + i), 2'b00, 1'b0);
    wr_err("thr_full_err", 3'd0, 8'hEE, 2'b00, 1'b1);
    wr_err("thr_full_pop_err", 3'd0, 8'hA5, 2'b01, 1'b0);
    @(posedge PCLK); #1 tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge PCLK);
      exp_tx = (i < 15) ? (32'h11 + 32'(i)) : 32'hA5;
      cmp("tx_drain_valid", {31'h0, tx_valid}, 32'h1);
      cmp("tx_drain_data", {24'h0, tx_data}, exp_tx);
    end
    @(posedge PCLK); #1 tx_ready = 1'b0;
    rd_chk("lsr_tx_empty", 3'd5, 2'b00, 8'h60);

    // 4: RX trigger interrupt
    wr(3'd1, 8'h01);
    wr(3'd2, 8'h80);
    for (int i = 0; i < 8; i++) rx_push(8'(8'h30 + i), 1'b0, 1'b0);
    @(negedge PCLK);
    cmp("irq_before_rise", {31'h0, irq}, 32'h0);
    @(negedge PCLK);
    cmp("irq_rise", {31'h0, irq}, 32'h1);
    rd_chk("isr_rxd", 3'd2, 2'b00, 8'hC4);
    rd_chk("rhr_first", 3'd0, 2'b00, 8'h30);
    @(negedge PCLK);
    cmp("irq_hold", {31'h0, irq}, 32'h1);
    @(negedge PCLK);
    cmp("irq_fall", {31'h0, irq}, 32'h0);

    // 5: RX overrun, parity error, sticky clear, set-wins on LSR read
    wr(3'd1, 8'h00);
    wr(3'd2, 8'h02);
    wr(3'd0, 8'h55);
    for (int i = 0; i < 17; i++) rx_push(8'(8'h40 + i), (i == 1) ? 1'b1 : 1'b0, 1'b0);
    wr(3'd1, 8'h04);
    rd_chk("isr_line", 3'd2, 2'b00, 8'hC6);
    rd_chk("lsr_errs", 3'd5, 2'b10, 8'h07);
    rd_chk("lsr_set_wins", 3'd5, 2'b00, 8'h0B);
    rd_chk("lsr_cleared", 3'd5, 2'b00, 8'h01);
    rd_chk("rhr_after_ovr", 3'd0, 2'b00, 8'h40);

    // 6: TX flush, reset with data in RX, THRE on enable
    wr(3'd0, 8'h77);
    wr(3'd2, 8'h04);
    @(negedge PCLK);
    cmp("tx_flushed", {31'h0, tx_valid}, 32'h0);
    wr(3'd2, 8'h02);
    for (int i = 0; i < 5; i++) rx_push(8'(8'h60 + i), 1'b0, 1'b0);
    @(posedge PCLK); #1 PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    rd_chk("lsr_after_reset", 3'd5, 2'b00, 8'h60);
    rd_chk("isr_after_reset", 3'd2, 2'b00, 8'hC1);
    cmp("divisor_after_reset", {16'h0, divisor}, 32'h0);
    wr(3'd1, 8'h02);
    rd_chk("isr_thre", 3'd2, 2'b00, 8'hC2);
    rd_chk("isr_thre_cleared", 3'd2, 2'b00, 8'hC1);
    repeat (3) @(posedge PCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
